// File: rtl/seg7_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Active-low one-hot anode patterns per scan index
    localparam logic [2:0] AN_ONES = 3'b110;
    localparam logic [2:0] AN_TENS = 3'b101;
    localparam logic [2:0] AN_HUND = 3'b011;
    localparam logic [2:0] AN_NONE = 3'b111;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/BCD_7Seg.sv
// BCD to 7-segment decoder, active-low segments ordered {a,b,c,d,e,f,g}.
// Codes above 9 (including the blank code 4'hF) turn every segment off.
module BCD_7Seg (
    input  logic [3:0] Binary_input,
    output logic [6:0] Seg_out
);

    always_comb begin
        Seg_out = 7'b1111111;
        case (Binary_input)
            4'd0: Seg_out = 7'b0000001;
            4'd1: Seg_out = 7'b1001111;
            4'd2: Seg_out = 7'b0010010;
            4'd3: Seg_out = 7'b0000110;
            4'd4: Seg_out = 7'b1001100;
            4'd5: Seg_out = 7'b0100100;
            4'd6: Seg_out = 7'b0100000;
            4'd7: Seg_out = 7'b0001111;
            4'd8: Seg_out = 7'b0000000;
            4'd9: Seg_out = 7'b0000100;
            default: Seg_out = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Binary-to-BCD conversion (sequential double-dabble) feeding a 3-digit
// time-multiplexed common-anode display with optional leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LEAD  = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] Value_in,
    input  logic       Load,
    output logic       Busy,
    output logic [6:0] Seg_out,
    output logic [2:0] An_out
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

    state_t      state;
    logic [7:0]  shift;
    logic [11:0] bcd;
    logic [2:0]  step;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;

    logic [PW-1:0] presc;
    logic [1:0]    idx;

    logic [11:0] bcd_adj;
    logic [19:0] dd_next;
    logic        blank_en;
    logic        hund_blank;
    logic        tens_blank;
    logic [3:0]  nibble;

    assign Busy = (state != IDLE);

    assign bcd_adj = {dabble_adj(bcd[11:8]), dabble_adj(bcd[7:4]), dabble_adj(bcd[3:0])};
    assign dd_next = {bcd_adj, shift} << 1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            shift <= '0;
            bcd   <= '0;
            step  <= '0;
            hund  <= '0;
            tens  <= '0;
            ones  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        shift <= Value_in;
                        bcd   <= '0;
                        step  <= '0;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd   <= dd_next[19:8];
                    shift <= dd_next[7:0];
                    step  <= step + 3'd1;
                    if (step == 3'd7) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    hund  <= bcd[11:8];
                    tens  <= bcd[7:4];
                    ones  <= bcd[3:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan timing runs free of the converter so the display never stalls
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (idx > IDX_LAST) begin
                idx <= '0;
            end else if (presc == PRESC_LAST) begin
                idx <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
            end
        end
    end

    assign blank_en   = (BLANK_LEAD != 0);
    assign hund_blank = blank_en && (hund == 4'd0);
    assign tens_blank = blank_en && (hund == 4'd0) && (tens == 4'd0);

    always_comb begin
        nibble = BLANK_CODE;
        An_out = AN_NONE;
        case (idx)
            2'd0: begin
                An_out = AN_ONES;
                nibble = ones;
            end
            2'd1: begin
                An_out = AN_TENS;
                nibble = tens_blank ? BLANK_CODE : tens;
            end
            2'd2: begin
                An_out = AN_HUND;
                nibble = hund_blank ? BLANK_CODE : hund;
            end
            default: begin
                An_out = AN_NONE;
                nibble = BLANK_CODE;
            end
        endcase
    end

    BCD_7Seg u_dec (
        .Binary_input (nibble),
        .Seg_out      (Seg_out)
    );

endmodule
